// File: rtl/pong_anim_graph_if.sv
// pong_anim_graph_if: pixel stream, buttons and scene outputs between the sync block and the pong pixel generator
interface pong_anim_graph_if;
  logic pixel_tick;
  logic video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic btn_up;
  logic btn_down;
  logic [11:0] rgb;
  logic miss;
  modport master (output pixel_tick, video_on, pixel_x, pixel_y, btn_up, btn_down, input rgb, miss);
  modport slave (input pixel_tick, video_on, pixel_x, pixel_y, btn_up, btn_down, output rgb, miss);
endinterface

// File: rtl/pong_anim_graph.sv
// pong_anim_graph: pong scene pixel generator with per-frame ball/paddle motion and a miss/serve sequence
module pong_anim_graph #(
  parameter logic [9:0] WALL_L = 10'd32, WALL_R = 10'd35, PAD_L = 10'd600, PAD_R = 10'd603,
  parameter logic [9:0] PAD_H = 10'd73, PAD_V = 10'd4, BALL_SIZE = 10'd9, BALL_V = 10'd2,
  parameter logic [9:0] X_MAX = 10'd640, Y_MAX = 10'd480,
  parameter logic [5:0] MISS_FRAMES = 6'd60
) (
  input logic clk,
  input logic rst,
  pong_anim_graph_if.slave bus
);
  localparam logic [9:0] BALL_X0 = 10'd580, BALL_Y0 = 10'd238, PAD_Y0 = 10'd204;
  typedef enum logic {PLAY, MISS} state_t;
  state_t state, state_d;
  logic [9:0] ball_x, ball_y, pad_top, ball_x_d, ball_y_d, pad_top_d;
  logic dir_x, dir_y, dir_x_d, dir_y_d;
  logic [5:0] miss_cnt, miss_cnt_d;
  logic [11:0] rgb, rgb_d;
  logic miss, miss_d, refr_tick, hit_pad, new_dx, new_dy, on_wall, on_pad, on_ball;
  assign bus.rgb = rgb;
  assign bus.miss = miss;
  // one pixel in vertical blank marks the frame boundary
  assign refr_tick = bus.pixel_tick && bus.pixel_x == 10'd0 && bus.pixel_y == 10'd481;
  assign hit_pad = dir_x && ball_x + BALL_SIZE - 10'd1 >= PAD_L && ball_x <= PAD_R &&
                   ball_y + BALL_SIZE - 10'd1 >= pad_top && ball_y <= pad_top + PAD_H - 10'd1;
  // dir_x 1 = right, dir_y 1 = down
  assign new_dx = ball_x <= WALL_R + 10'd1 ? 1'b1 : hit_pad ? 1'b0 : dir_x;
  assign new_dy = ball_y <= 10'd1 ? 1'b1 : ball_y + BALL_SIZE - 10'd1 >= Y_MAX - 10'd2 ? 1'b0 : dir_y;
  always_comb begin
    state_d = state;
    ball_x_d = ball_x;
    ball_y_d = ball_y;
    dir_x_d = dir_x;
    dir_y_d = dir_y;
    pad_top_d = pad_top;
    miss_cnt_d = miss_cnt;
    miss_d = 1'b0;
    if (refr_tick) begin
      pad_top_d = (bus.btn_down && !bus.btn_up && pad_top + PAD_H - 10'd1 < Y_MAX - 10'd1 - PAD_V) ? pad_top + PAD_V :
                  (bus.btn_up && !bus.btn_down && pad_top > PAD_V) ? pad_top - PAD_V : pad_top;
      if (state == PLAY && ball_x > PAD_R) begin
        state_d = MISS;
        miss_d = 1'b1;
        miss_cnt_d = '0;
      end else if (state == PLAY) begin
        dir_x_d = new_dx;
        dir_y_d = new_dy;
        ball_x_d = new_dx ? ball_x + BALL_V : ball_x - BALL_V;
        ball_y_d = new_dy ? ball_y + BALL_V : ball_y - BALL_V;
      end else if (miss_cnt == MISS_FRAMES - 6'd1) begin
        state_d = PLAY;
        ball_x_d = BALL_X0;
        ball_y_d = BALL_Y0;
        dir_x_d = 1'b0;
        dir_y_d = 1'b0;
      end else begin
        miss_cnt_d = miss_cnt + 6'd1;
      end
    end
  end
  assign on_wall = bus.pixel_x >= WALL_L && bus.pixel_x <= WALL_R;
  assign on_pad = bus.pixel_x >= PAD_L && bus.pixel_x <= PAD_R &&
                  bus.pixel_y >= pad_top && bus.pixel_y <= pad_top + PAD_H - 10'd1;
  assign on_ball = state == PLAY && bus.pixel_x >= ball_x && bus.pixel_x <= ball_x + BALL_SIZE - 10'd1 &&
                   bus.pixel_y >= ball_y && bus.pixel_y <= ball_y + BALL_SIZE - 10'd1;
  assign rgb_d = !(bus.video_on && bus.pixel_x < X_MAX) ? 12'h000 : on_wall ? 12'h00f :
                 on_pad ? 12'h0f0 : on_ball ? 12'hf00 : 12'h000;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PLAY;
      ball_x <= BALL_X0;
      ball_y <= BALL_Y0;
      dir_x <= 1'b0;
      dir_y <= 1'b0;
      pad_top <= PAD_Y0;
      miss_cnt <= '0;
      miss <= 1'b0;
      rgb <= '0;
    end else begin
      state <= state_d;
      ball_x <= ball_x_d;
      ball_y <= ball_y_d;
      dir_x <= dir_x_d;
      dir_y <= dir_y_d;
      pad_top <= pad_top_d;
      miss_cnt <= miss_cnt_d;
      miss <= miss_d;
      rgb <= bus.pixel_tick ? rgb_d : rgb;
    end
  end
endmodule

// File: tb/tb_pong_anim_graph.sv
// tb_pong_anim_graph: scenario tasks drive pixels/frames; a monitor pops expected rgb per pixel tick
module tb_pong_anim_graph;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  pong_anim_graph_if bus();
  pong_anim_graph dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  string name_q[$];
  int mbx, mby, mpad, mcnt;
  bit mdx, mdy, mplay;
  logic [11:0] mon_e;
  string mon_n;
  always @(posedge clk) if (bus.pixel_tick) begin
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_tick rgb=%h", bus.rgb);
    end else begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      checks++;
      if (bus.rgb !== mon_e) begin
        errors++;
        $display("FAIL %s rgb=%h expected=%h", mon_n, bus.rgb, mon_e);
      end
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic model_reset();
    mbx = 580; mby = 238; mdx = 0; mdy = 0; mpad = 204; mplay = 1; mcnt = 0;
  endtask
  function automatic logic [11:0] exp_rgb(int x, int y);
    if (x >= 32 && x <= 35) return 12'h00f;
    if (x >= 600 && x <= 603 && y >= mpad && y <= mpad + 72) return 12'h0f0;
    if (mplay && x >= mbx && x <= mbx + 8 && y >= mby && y <= mby + 8) return 12'hf00;
    return 12'h000;
  endfunction
  task automatic model_step(input bit up, input bit dn);
    if (mplay) begin
      if (mbx > 603) begin
        mplay = 0; mcnt = 0;
      end else begin
        if (mby <= 1) mdy = 1; else if (mby + 8 >= 478) mdy = 0;
        if (mbx <= 36) mdx = 1;
        else if (mdx && mbx + 8 >= 600 && mbx <= 603 && mby <= mpad + 72 && mby + 8 >= mpad) mdx = 0;
        mbx += mdx ? 2 : -2;
        mby += mdy ? 2 : -2;
      end
    end else if (mcnt == 59) begin
      mbx = 580; mby = 238; mdx = 0; mdy = 0; mplay = 1;
    end else mcnt++;
    if (dn && !up && mpad + 72 < 475) mpad += 4;
    else if (up && !dn && mpad > 4) mpad -= 4;
  endtask
  task automatic probe(input int x, input int y, input bit von, input logic [11:0] e, input string nm);
    @(negedge clk);
    bus.pixel_x = 10'(x); bus.pixel_y = 10'(y); bus.video_on = von; bus.pixel_tick = 1;
    exp_q.push_back(e); name_q.push_back(nm);
    @(posedge clk); #1;
    bus.pixel_tick = 0;
  endtask
  task automatic frame(input bit up, input bit dn);
    bit em;
    em = mplay && mbx > 603;
    @(negedge clk);
    bus.btn_up = up; bus.btn_down = dn;
    bus.pixel_x = 0; bus.pixel_y = 481; bus.video_on = 0; bus.pixel_tick = 1;
    exp_q.push_back(12'h000); name_q.push_back("frame_rgb");
    @(posedge clk); #1;
    bus.pixel_tick = 0;
    checks++;
    if (bus.miss !== em) begin errors++; $display("FAIL miss_pulse miss=%b expected=%b", bus.miss, em); end
    if (em) begin
      @(posedge clk); #1;
      checks++;
      if (bus.miss !== 1'b0) begin errors++; $display("FAIL miss_width miss=%b expected=0", bus.miss); end
    end
    model_step(up, dn);
  endtask
  task automatic check_ball(input string nm);
    probe(mbx, mby, 1, exp_rgb(mbx, mby), {nm, "_tl"});
    probe(mbx + 8, mby + 8, 1, exp_rgb(mbx + 8, mby + 8), {nm, "_br"});
    probe(mbx - 1, mby, 1, exp_rgb(mbx - 1, mby), {nm, "_left"});
    probe(mbx + 9, mby + 8, 1, exp_rgb(mbx + 9, mby + 8), {nm, "_right"});
    probe(mbx, mby + 9, 1, exp_rgb(mbx, mby + 9), {nm, "_below"});
  endtask
  task automatic test_reset();
    rst = 1;
    bus.pixel_tick = 0; bus.video_on = 0; bus.pixel_x = 0; bus.pixel_y = 0;
    bus.btn_up = 0; bus.btn_down = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb rgb=%h expected=000", bus.rgb); end
    checks++;
    if (bus.miss !== 1'b0) begin errors++; $display("FAIL reset_miss miss=%b expected=0", bus.miss); end
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_frame0();
    probe(33, 100, 1, 12'h00f, "f0_wall");
    probe(33, 100, 0, 12'h000, "f0_blank");
    probe(584, 240, 1, 12'hf00, "f0_ball");
    probe(300, 300, 1, 12'h000, "f0_bg");
    probe(700, 100, 1, 12'h000, "f0_right");
    probe(601, 240, 1, 12'h0f0, "f0_pad");
    @(negedge clk);
    bus.pixel_x = 300; bus.pixel_y = 300;
    @(posedge clk); #1;
    checks++;
    if (bus.rgb !== 12'h0f0) begin errors++; $display("FAIL rgb_hold rgb=%h expected=0f0", bus.rgb); end
  endtask
  task automatic test_motion();
    frame(0, 0);
    probe(578, 236, 1, 12'hf00, "mv1_tl");
    probe(586, 244, 1, 12'hf00, "mv1_br");
    probe(577, 236, 1, 12'h000, "mv1_left");
    probe(578, 235, 1, 12'h000, "mv1_above");
    repeat (118) frame(0, 0);
    probe(342, 0, 1, 12'hf00, "top_tl");
    probe(350, 8, 1, 12'hf00, "top_br");
    probe(342, 9, 1, 12'h000, "top_below");
    frame(0, 0);
    probe(340, 2, 1, 12'hf00, "bounce_tl");
    probe(340, 1, 1, 12'h000, "bounce_above");
    frame(0, 0);
    probe(338, 4, 1, 12'hf00, "down_tl");
    probe(338, 3, 1, 12'h000, "down_above");
    check_ball("motion");
  endtask
  task automatic test_paddle();
    int n;
    repeat (3) frame(0, 1);
    probe(601, 216, 1, 12'h0f0, "pad_dn_top");
    probe(601, 215, 1, 12'h000, "pad_dn_above");
    probe(601, 288, 1, 12'h0f0, "pad_dn_bot");
    probe(601, 289, 1, 12'h000, "pad_dn_below");
    repeat (5) frame(1, 1);
    probe(601, 216, 1, 12'h0f0, "pad_both_top");
    probe(601, 215, 1, 12'h000, "pad_both_above");
    n = 0;
    while (mpad > 4 && n < 100) begin frame(1, 0); n++; end
    repeat (5) frame(1, 0);
    probe(601, 4, 1, 12'h0f0, "pad_lim_top");
    probe(601, 3, 1, 12'h000, "pad_lim_above");
    probe(601, 76, 1, 12'h0f0, "pad_lim_bot");
    probe(601, 77, 1, 12'h000, "pad_lim_below");
  endtask
  task automatic test_wall();
    int n = 0;
    while (mbx != 36 && n < 400) begin frame(0, 0); n++; end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL wall_reach frames=%0d limit=400", n); end
    check_ball("wall_at36");
    probe(35, mby, 1, 12'h00f, "wall_edge");
    frame(0, 0);
    probe(38, mby, 1, 12'hf00, "wall_bounce_tl");
    probe(37, mby, 1, 12'h000, "wall_bounce_left");
  endtask
  task automatic test_paddle_hit();
    int n = 0;
    int t;
    while (!(mbx == 592 && mdx) && n < 800) begin
      t = mby - 32;
      frame(mpad >= t + 4, mpad + 4 <= t);
      n++;
    end
    checks++;
    if (n >= 800) begin errors++; $display("FAIL pad_reach frames=%0d limit=800", n); end
    check_ball("pad_at592");
    frame(0, 0);
    probe(590, mby, 1, 12'hf00, "pad_hit_tl");
    probe(599, mby, 1, 12'h000, "pad_hit_right");
  endtask
  task automatic test_miss();
    int n = 0;
    while (mpad > 4 && n < 150) begin frame(1, 0); n++; end
    n = 0;
    while (mplay && n < 6000) begin frame(0, 0); n++; end
    checks++;
    if (n >= 6000) begin errors++; $display("FAIL miss_reach frames=%0d limit=6000", n); end
    for (int i = 0; i < 60; i++) begin
      probe(mbx, mby, 1, 12'h000, "hidden_tl");
      probe(mbx + 4, mby + 4, 1, 12'h000, "hidden_mid");
      frame(0, i < 2);
    end
    probe(601, 12, 1, 12'h0f0, "miss_pad_top");
    probe(601, 11, 1, 12'h000, "miss_pad_above");
    probe(580, 238, 1, 12'hf00, "serve_tl");
    probe(588, 246, 1, 12'hf00, "serve_br");
    probe(579, 238, 1, 12'h000, "serve_left");
    frame(0, 0);
    probe(578, 236, 1, 12'hf00, "serve_mv_tl");
    probe(578, 235, 1, 12'h000, "serve_mv_above");
  endtask
  task automatic test_reset_mid();
    repeat (10) frame(0, 1);
    probe(33, 100, 1, 12'h00f, "pre_rst_wall");
    @(negedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if (bus.rgb !== 12'h000) begin errors++; $display("FAIL async_rst_rgb rgb=%h expected=000", bus.rgb); end
    checks++;
    if (bus.miss !== 1'b0) begin errors++; $display("FAIL async_rst_miss miss=%b expected=0", bus.miss); end
    model_reset();
    bus.btn_down = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    test_frame0();
  endtask
  initial begin
    test_reset();
    test_frame0();
    test_motion();
    test_paddle();
    test_wall();
    test_paddle_hit();
    test_miss();
    test_reset_mid();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
